dmem_bridge: RTL

Sits between the single-cycle MIPS core's data-memory port and a slower word-addressed data RAM that uses a req/ack handshake.
- Writes are posted through a one-entry write buffer, so the core does not stall on an isolated sw.
- Reads stall the core until the RAM acknowledges.
- A bus timeout and sticky error flags protect the core from a hung RAM.

---
 rtl/dmem_bridge_if.sv | 22 ++
 rtl/dmem_bridge.sv | 102 ++++++++++
 2 files changed

// File: rtl/dmem_bridge_if.sv
// Bus-side handshake bundle between dmem_bridge and the data RAM.
// master: bridge drives req/we/addr/wdata; slave: RAM drives ack/rdata.
interface dmem_bridge_if #(
  parameter int ADDR_W = 6
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Core data-port to req/ack RAM bridge: posted writes, stalled reads,
// bus timeout. Ports: core side (memread/memwrite/addr/wdata/rdata/stall),
// bus side via dmem_bridge_if.master, sticky err_timeout/err_align.
module dmem_bridge #(
  parameter int          ADDR_W   = 6,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  dmem_bridge_if.master bus,
  output logic        err_timeout,
  output logic        err_align
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD      = 2'd2;
  localparam logic [1:0] RD_DONE = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          hit;
  logic          expire;
  logic          unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign hit    = bus.bus_req & bus.bus_ack;
  // Abort on the edge that would make the count reach TIMEOUT,
  // so bus_req stays high for exactly TIMEOUT cycles.
  assign expire = bus.bus_req & ~bus.bus_ack
                & (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    stall = reset
          & ((memread  & (state != RD_DONE))
          |  (memwrite & (state != IDLE)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rdata         <= '0;
      err_timeout   <= 1'b0;
      err_align     <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memread | memwrite) begin
            // Read wins if both are asserted; the write is dropped.
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= ~memread;
            bus.bus_addr  <= addr[ADDR_W+1:2];
            bus.bus_wdata <= wdata;
            cnt           <= '0;
            state         <= memread ? RD : WR;
            if (addr[1:0] != 2'b00) err_align <= 1'b1;
          end
        end
        WR, RD: begin
          if (hit) begin
            bus.bus_req <= 1'b0;
            if (state == RD) begin
              rdata <= bus.bus_rdata;
              state <= RD_DONE;
            end else begin
              state <= IDLE;
            end
          end else if (expire) begin
            bus.bus_req <= 1'b0;
            err_timeout <= 1'b1;
            if (state == RD) begin
              rdata <= ERR_DATA;
              state <= RD_DONE;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
